// File: rtl/mem_bus_arbiter_if.sv
// External memory bus shared by the fetch and data ports of mem_bus_arbiter.
// The master drives request fields; the slave (memory) returns ack and read data.
interface mem_bus_arbiter_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_err_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  // Handshake: the master raises bus_req_o with we/addr/sel/wdata stable and holds them
  // until the edge where bus_ack_i=1 (bus_rdata_i valid on that edge), or until it aborts
  // the cycle itself, which it flags with a one-cycle bus_err_o pulse.
  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one req/ack memory bus between the MEM data port (priority) and the IF fetch port,
// buffers each port's result until the pipeline consumes it, and aborts stuck cycles on timeout.
module mem_bus_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [3:0]        d_sel_i,
  input  logic [31:0]       d_wdata_i,
  input  logic              d_hold_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_stallreq_o,
  input  logic              i_ce_i,
  input  logic [31:0]       i_addr_i,
  input  logic              i_hold_i,
  output logic [31:0]       i_rdata_o,
  output logic              i_stallreq_o,
  output logic [1:0]        state_o,
  mem_bus_arbiter_if.master bus
);
  // state_o encoding: 0 idle, 1 data cycle on the bus, 2 fetch cycle on the bus
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_D = 2'd1, BUSY_I = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flushed_q, flushed_d;
  logic             d_done_q, d_done_d, i_done_q, i_done_d;
  logic [31:0]      d_buf_q, d_buf_d, i_buf_q, i_buf_d;
  logic             req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;

  logic        busy, timeout, finish, keep, d_issue, i_issue;
  logic [31:0] result;

  assign busy    = (state_q != IDLE);
  assign finish  = busy & (bus.bus_ack_i | (cnt_q == CNT_LAST));
  assign timeout = busy & ~bus.bus_ack_i & (cnt_q == CNT_LAST);
  // A flush seen at any point of the cycle, including the completing edge, discards the result.
  assign keep    = ~(flushed_q | flush_i);
  assign d_issue = (state_q == IDLE) & ~flush_i & d_ce_i & ~d_done_q;
  assign i_issue = (state_q == IDLE) & ~flush_i & ~(d_ce_i & ~d_done_q) & i_ce_i & ~i_done_q;
  assign result  = (timeout | we_q) ? 32'h0 : bus.bus_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      d_done_q  <= 1'b0;
      i_done_q  <= 1'b0;
      d_buf_q   <= '0;
      i_buf_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      d_done_q  <= d_done_d;
      i_done_q  <= i_done_d;
      d_buf_q   <= d_buf_d;
      i_buf_q   <= i_buf_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_issue)      state_d = BUSY_D;
        else if (i_issue) state_d = BUSY_I;
      end
      BUSY_D, BUSY_I: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    d_buf_d   = d_buf_q;
    i_buf_d   = i_buf_q;
    // A buffered result survives only while that port's pipeline register is frozen.
    d_done_d  = d_done_q & d_hold_i & ~flush_i;
    i_done_d  = i_done_q & i_hold_i & ~flush_i;
    if (d_issue) begin
      req_d   = 1'b1;
      we_d    = d_we_i;
      addr_d  = d_addr_i;
      sel_d   = d_sel_i;
      wdata_d = d_wdata_i;
    end else if (i_issue) begin
      req_d   = 1'b1;
      we_d    = 1'b0;
      addr_d  = i_addr_i;
      sel_d   = 4'hf;
      wdata_d = '0;
    end
    if (busy) begin
      cnt_d     = cnt_q + CNT_W'(1);
      flushed_d = flushed_q | flush_i;
      if (finish) begin
        cnt_d     = '0;
        flushed_d = 1'b0;
        req_d     = 1'b0;
        we_d      = 1'b0;
        addr_d    = '0;
        sel_d     = '0;
        wdata_d   = '0;
        err_d     = timeout;
        if (state_q == BUSY_D) begin
          d_buf_d = result;
          if (keep) d_done_d = 1'b1;
        end else begin
          i_buf_d = result;
          if (keep) i_done_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    d_stallreq_o = d_ce_i & ~d_done_q;
    i_stallreq_o = i_ce_i & ~i_done_q;
    d_rdata_o    = d_done_q ? d_buf_q : 32'h0;
    i_rdata_o    = i_done_q ? i_buf_q : 32'h0;
    state_o      = state_q;
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_sel_o   = sel_q;
  assign bus.bus_wdata_o = wdata_q;
  assign bus.bus_err_o   = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a pipeline driver, a memory slave with random ack
// latency (including timeouts), and a transaction-level model of issue order and results.
module tb_mem_bus_arbiter;
  localparam int TO       = 256;
  localparam int N_CYCLES = 6000;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        d_ce, d_we, d_hold;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic        i_ce, i_hold;
  logic [31:0] i_addr;
  logic [31:0] d_rdata, i_rdata;
  logic        d_stall, i_stall;
  logic [1:0]  state;

  mem_bus_arbiter_if bus_if();

  mem_bus_arbiter #(.ACK_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .d_ce_i(d_ce), .d_we_i(d_we), .d_addr_i(d_addr), .d_sel_i(d_sel),
    .d_wdata_i(d_wdata), .d_hold_i(d_hold), .d_rdata_o(d_rdata), .d_stallreq_o(d_stall),
    .i_ce_i(i_ce), .i_addr_i(i_addr), .i_hold_i(i_hold), .i_rdata_o(i_rdata),
    .i_stallreq_o(i_stall), .state_o(state), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Scoreboard: bus cycles the model expects to start next, {is_data, we, sel, addr, wdata}
  logic [69:0] exp_q[$];
  logic [69:0] e;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bit          has_d, has_i, cur_valid, cur_d, cur_we, cur_flushed, ack;
  logic [31:0] res_d, res_i, cur_addr, cur_wdata, p_rdata;
  logic [3:0]  cur_sel;
  int          busy_n, lat, cyc;
  bit          p_rst, p_flush, p_hold_d, p_hold_i, p_ack, p_timeout, d_adv, i_adv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
  endtask

  task automatic tick();
    logic [31:0] r;
    @(negedge clk);
    cyc++;
    // Apply the effect of the edge just passed to the model.
    if (p_rst) begin
      has_d = 0; has_i = 0; cur_valid = 0;
      exp_q.delete();
    end else begin
      if (has_d && (!p_hold_d || p_flush)) has_d = 0;
      if (has_i && (!p_hold_i || p_flush)) has_i = 0;
      if (cur_valid) begin
        if (p_flush) cur_flushed = 1;
        if (p_ack || p_timeout) begin
          r = (p_timeout || cur_we) ? 32'h0 : p_rdata;
          if (!cur_flushed) begin
            if (cur_d) begin has_d = 1; res_d = r; end
            else       begin has_i = 1; res_i = r; end
          end
          cur_valid = 0;
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cur_d = e[69]; cur_we = e[68]; cur_sel = e[67:64];
        cur_addr = e[63:32]; cur_wdata = e[31:0];
        cur_valid = 1; cur_flushed = 0; busy_n = 0;
        lat = ($urandom_range(0, 9) == 0) ? TO + 10 : int'($urandom_range(1, 4));
      end
    end

    check_eq("bus_req", bus_if.bus_req_o, cur_valid);
    check_eq("bus_err", bus_if.bus_err_o, p_timeout && !p_rst);
    check_eq("state", state, cur_valid ? (cur_d ? 1 : 2) : 0);
    if (cur_valid) begin
      check_eq("bus_addr", bus_if.bus_addr_o, cur_addr);
      check_eq("bus_we", bus_if.bus_we_o, cur_we);
      check_eq("bus_sel", bus_if.bus_sel_o, cur_sel);
      if (cur_d) check_eq("bus_wdata", bus_if.bus_wdata_o, cur_wdata);
    end
    if (p_rst) begin
      check_eq("rst_addr", bus_if.bus_addr_o, 0);
      check_eq("rst_we", bus_if.bus_we_o, 0);
      check_eq("rst_sel", bus_if.bus_sel_o, 0);
      check_eq("rst_wdata", bus_if.bus_wdata_o, 0);
    end
    check_eq("d_stall", d_stall, d_ce && !has_d);
    check_eq("i_stall", i_stall, i_ce && !has_i);
    check_eq("d_rdata", d_rdata, has_d ? res_d : 32'h0);
    check_eq("i_rdata", i_rdata, has_i ? res_i : 32'h0);

    // Memory slave; acks while idle are stray and must be ignored.
    if (cur_valid) begin
      busy_n++;
      ack = (busy_n == lat);
      p_ack = ack;
      p_timeout = !ack && (busy_n == TO);
    end else begin
      ack = ($urandom_range(0, 3) == 0);
      p_ack = 0;
      p_timeout = 0;
    end
    bus_if.bus_ack_i   = ack;
    bus_if.bus_rdata_i = $urandom();
    p_rdata = bus_if.bus_rdata_i;

    // Pipeline: a port presents a new request once its result was consumed or flushed.
    if (d_adv || !d_ce || p_flush || p_rst) begin
      d_ce = ($urandom_range(0, 3) != 0);
      d_we = 1'($urandom_range(0, 1));
      d_addr = $urandom();
      d_sel = 4'($urandom_range(0, 15));
      d_wdata = $urandom();
    end
    if (i_adv || !i_ce || p_flush || p_rst) begin
      i_ce = ($urandom_range(0, 3) != 0);
      i_addr = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    end
    d_hold = 1'($urandom_range(0, 1));
    i_hold = 1'($urandom_range(0, 1));
    d_adv = has_d && !d_hold;
    i_adv = has_i && !i_hold;
    rst   = (cyc < 3) || ($urandom_range(0, 299) == 0);
    flush = ($urandom_range(0, 19) == 0);

    // Idle bus: next edge starts the data port if it is waiting, else the fetch port.
    if (!cur_valid && !rst && !flush) begin
      if (d_ce && !has_d)      exp_q.push_back({1'b1, d_we, d_sel, d_addr, d_wdata});
      else if (i_ce && !has_i) exp_q.push_back({1'b0, 1'b0, 4'hf, i_addr, 32'h0});
    end
    p_rst = rst; p_flush = flush; p_hold_d = d_hold; p_hold_i = i_hold;
  endtask

  initial begin
    rst = 1; flush = 0;
    d_ce = 0; d_we = 0; d_addr = 0; d_sel = 0; d_wdata = 0; d_hold = 0;
    i_ce = 0; i_addr = 0; i_hold = 0;
    bus_if.bus_ack_i = 0; bus_if.bus_rdata_i = 0;
    p_rst = 1; p_flush = 0; p_hold_d = 0; p_hold_i = 0; p_ack = 0; p_timeout = 0; p_rdata = 0;
    has_d = 0; has_i = 0; res_d = 0; res_i = 0; cur_valid = 0; cur_d = 0; cur_we = 0;
    cur_flushed = 0; cur_sel = 0; cur_addr = 0; cur_wdata = 0;
    busy_n = 0; lat = 1; cyc = 0; d_adv = 0; i_adv = 0; ack = 0;
    repeat (N_CYCLES) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
